mire_writer: RTL
================

// Module: mire_writer
// PURPOSE
//  Wishbone master that fills the SDRAM framebuffer with a grid test pattern ("mire"), frame after frame.
//  Upstream stage of the VGA framebuffer reader: shares the SDRAM wishbone port through the arbiter.
//  Periodically releases the bus so the VGA reader is not starved.
// PARAMETERS
//  HDISP        800  active pixels per line
//  VDISP        480  active lines per frame
//  PAUSE_EVERY  64   acked writes between forced bus releases (>=1)
//  GRID         16   grid pitch in pixels, power of 2
// PORTS
//  sys_clk      in   1   system clock, 100 MHz
//  sys_rst      in   1   asynchronous, active-high reset
//  enable       in   1   level; 1 = generate writes
//  cyc_o        out  1   wishbone cycle
//  stb_o        out  1   wishbone strobe
//  we_o         out  1   write enable, always 1 while stb_o
//  adr_o        out  32  byte address = 4*(y*HDISP+x)
//  dat_o        out  32  pixel {8'h00,R,G,B}
//  sel_o        out  4   byte lanes, 4'hF while stb_o else 0
//  cti_o        out  3   3'b000 (classic cycle)
//  bte_o        out  2   2'b00
//  ack_i        in   1   slave acknowledge
//  err_i        in   1   slave error
//  frame_done   out  1   1-cycle pulse on ack of last pixel of a frame
//  frame_cnt    out  8   completed frames, wraps 255->0
// BEHAVIOUR
//  Reset: cyc_o=stb_o=we_o=0, adr_o=0, dat_o=0, sel_o=0, frame_done=0, frame_cnt=0, x=y=0, pause_cnt=0, state IDLE.
//  Pixel: white 32'h00FFFFFF if x%GRID==0 or y%GRID==0 or x==HDISP-1 or y==VDISP-1; else black 32'h0.
//  FSM IDLE: enable=1 -> WRITE next cycle (cyc_o=stb_o=1, adr/dat of current x,y registered in same edge).
//  FSM WRITE: cyc/stb/adr/dat held stable until ack_i or err_i; no combinational path ack_i->stb_o.
//   ack_i: advance x; x==HDISP-1 -> x=0,y++; also y==VDISP-1 -> y=0, frame_done pulse, frame_cnt++.
//   ack_i: pause_cnt++; reaching PAUSE_EVERY -> pause_cnt=0, go PAUSE (cyc=stb=0).
//   ack_i with enable=0 -> IDLE (cyc=stb=0), position kept; resume exactly at next pixel.
//   otherwise next pixel issued on the cycle after ack (stb low 0 cycles: new adr/dat with stb still 1).
//   err_i (ack_i=0): no advance, cycle dropped 1 clock (PAUSE), same pixel retried; pause_cnt unchanged.
//   ack_i and err_i together: treated as ack.
//  FSM PAUSE: exactly 1 cycle cyc_o=stb_o=0, then WRITE if enable else IDLE.
//  enable falling during WRITE never aborts a pending transfer.
//  Throughput: 1 pixel per ack; bus released >=1 cycle every PAUSE_EVERY pixels.
//  Address width: y*HDISP+x computed in 32 bits; x uses clog2(HDISP), y clog2(VDISP) bits.
//  sys_rst mid-transfer: outputs drop asynchronously, restart at pixel (0,0).
// TESTING (bench with HDISP=8, VDISP=4, PAUSE_EVERY=4, GRID=4, slave acks 1 cycle after stb)
//  Reset then enable=1 -> first stb: adr=0, dat=00FFFFFF; pixel(1,1) adr=0x24 dat=0.
//  Run full frame -> 32 writes, addresses 0..0x7C step 4, frame_done single pulse on 32nd ack, frame_cnt=1.
//  Count stb low gaps -> one 1-cycle cyc_o=0 after every 4th ack; no gap otherwise.
//  Slave stalls ack 5 cycles -> adr/dat/stb stable all 5 cycles; err_i on pixel 3 -> pixel 3 reissued, same adr.
//  Drop enable mid-line at pixel 10 -> pending write completes, bus idle; re-enable -> next adr=0x2C.
//  Run 256 frames -> frame_cnt wraps to 0; assert sys_rst mid-stb -> cyc_o=0 immediately, restart adr=0.

Source files
------------

// File: rtl/mire_wb_if.sv
// Wishbone classic bus between the mire writer (master) and the SDRAM arbiter (slave).
interface mire_wb_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        ack_i;
  logic        err_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o, bte_o,
    input  ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, cti_o, bte_o,
    output ack_i, err_i
  );
endinterface

// File: rtl/mire_writer.sv
// Wishbone master painting a grid test pattern into the framebuffer, one pixel per ack,
// releasing the bus for one cycle every PAUSE_EVERY pixels so the VGA reader is not starved.
module mire_writer #(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int PAUSE_EVERY = 64,
  parameter int GRID        = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             enable,
  mire_wb_if.master        wb,
  output logic             frame_done,
  output logic [7:0]       frame_cnt
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int PW = $clog2(PAUSE_EVERY + 1);

  localparam logic [XW-1:0] X_LAST    = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(VDISP - 1);
  localparam logic [PW-1:0] P_LAST    = PW'(PAUSE_EVERY - 1);
  localparam logic [31:0]   GRID_MASK = 32'(GRID - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_PAUSE
  } state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  function automatic logic [31:0] pix_adr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [31:0] lin;
    lin = 32'(y) * 32'(HDISP) + 32'(x);
    return {lin[29:0], 2'b00};
  endfunction

  // Grid lines every GRID pixels plus a closing border on the last column and row.
  function automatic logic [31:0] pix_dat(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic on_grid;
    on_grid = ((32'(x) & GRID_MASK) == 32'd0) || ((32'(y) & GRID_MASK) == 32'd0) ||
              (x == X_LAST) || (y == Y_LAST);
    return on_grid ? 32'h00FF_FFFF : 32'h0000_0000;
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pause_d      = pause_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WRITE;
      end

      S_WRITE: begin
        if (wb.ack_i) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 8'd1;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end

          if (pause_q == P_LAST) begin
            pause_d = '0;
            state_d = S_PAUSE;
          end else begin
            pause_d = pause_q + 1'b1;
            if (!enable) state_d = S_IDLE;
          end
        end else if (wb.err_i) begin
          // Retry the same pixel after a one-cycle bus drop.
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        state_d = enable ? S_WRITE : S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Address and data are loaded on the same edge that raises or keeps stb.
    if (state_d == S_WRITE) begin
      adr_d = pix_adr(x_d, y_d);
      dat_d = pix_dat(x_d, y_d);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together
  // from the values seen before the edge.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      pause_q      <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pause_q      <= pause_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign wb.cyc_o   = (state_q == S_WRITE);
  assign wb.stb_o   = (state_q == S_WRITE);
  assign wb.we_o    = (state_q == S_WRITE);
  assign wb.sel_o   = (state_q == S_WRITE) ? 4'hF : 4'h0;
  assign wb.cti_o   = 3'b000;
  assign wb.bte_o   = 2'b00;
  assign wb.adr_o   = adr_q;
  assign wb.dat_o   = dat_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
